// File: rtl/intersection_phase_scheduler_pkg.sv
// rtl/intersection_phase_scheduler_pkg.sv - state encoding, default timing and helpers
package intersection_phase_scheduler_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ALL_RED = 3'd1;
  localparam logic [2:0] ST_GREEN   = 3'd2;
  localparam logic [2:0] ST_YELLOW  = 3'd3;
  localparam logic [2:0] ST_WALK    = 3'd4;

  localparam int unsigned DEF_G_MIN     = 4;
  localparam int unsigned DEF_G_MAX     = 10;
  localparam int unsigned DEF_Y_TIME    = 2;
  localparam int unsigned DEF_AR_TIME   = 1;
  localparam int unsigned DEF_WALK_TIME = 3;

  function automatic logic [3:0] dir_onehot(input logic [1:0] dir);
    return 4'b0001 << dir;
  endfunction

endpackage

// File: rtl/intersection_phase_scheduler_rr_arbiter4.sv
// rtl/intersection_phase_scheduler_rr_arbiter4.sv - four-way round-robin pick after ptr
module rr_arbiter4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       grant_valid,
  output logic [1:0] grant_idx
);

  logic [1:0] idx;

  // Walk from farthest to nearest so the approach just after ptr wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = ptr;
    idx         = ptr;
    for (int i = 4; i >= 1; i--) begin
      idx = ptr + 2'(i);
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/intersection_phase_scheduler.sv
// rtl/intersection_phase_scheduler.sv - four-approach signal phase FSM with pedestrian and emergency service
module intersection_phase_scheduler
  import intersection_phase_scheduler_pkg::*;
#(
  parameter int unsigned G_MIN     = DEF_G_MIN,
  parameter int unsigned G_MAX     = DEF_G_MAX,
  parameter int unsigned Y_TIME    = DEF_Y_TIME,
  parameter int unsigned AR_TIME   = DEF_AR_TIME,
  parameter int unsigned WALK_TIME = DEF_WALK_TIME
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] req,
  input  logic       ped_req,
  input  logic       emg_valid,
  input  logic [1:0] emg_dir,
  output logic [3:0] green,
  output logic [3:0] yellow,
  output logic [3:0] red,
  output logic       walk,
  output logic [1:0] cur_dir,
  output logic       phase_done
);

  localparam logic [7:0] G_MIN_LAST = 8'(G_MIN - 1);
  localparam logic [7:0] G_MAX_LAST = 8'(G_MAX - 1);
  localparam logic [7:0] Y_LAST     = 8'(Y_TIME - 1);
  localparam logic [7:0] AR_LAST    = 8'(AR_TIME - 1);
  localparam logic [7:0] W_LAST     = 8'(WALK_TIME - 1);

  logic [2:0] state, state_next;
  logic [7:0] timer, timer_next;
  logic [1:0] rr_ptr, ptr_next, dir_next;
  logic       ped_pending, ped_next, enter_walk, other_demand;
  logic       rr_valid;
  logic [1:0] rr_idx;
  logic [3:0] green_d, yellow_d;
  logic       done_d;

  rr_arbiter4 u_rr_arbiter4 (
    .req         (req),
    .ptr         (rr_ptr),
    .grant_valid (rr_valid),
    .grant_idx   (rr_idx)
  );

  always_comb begin
    state_next   = state;
    dir_next     = cur_dir;
    ptr_next     = rr_ptr;
    other_demand = (|(req & ~dir_onehot(cur_dir))) || ped_pending;
    case (state)
      ST_IDLE: if (start) state_next = ST_ALL_RED;
      // Past the clearance time ALL_RED re-evaluates every cycle until something is served.
      ST_ALL_RED: if (timer >= AR_LAST) begin
        if (emg_valid) begin
          state_next = ST_GREEN;
          dir_next   = emg_dir;
          ptr_next   = emg_dir;
        end else if (ped_pending) begin
          state_next = ST_WALK;
        end else if (rr_valid) begin
          state_next = ST_GREEN;
          dir_next   = rr_idx;
          ptr_next   = rr_idx;
        end
      end
      // Demand first seen after G_MIN is held off until G_MAX; a saturated timer releases at once.
      ST_GREEN: begin
        if (emg_valid) begin
          if (emg_dir != cur_dir) state_next = ST_YELLOW;
        end else if (other_demand && (timer == G_MIN_LAST || timer >= G_MAX_LAST)) begin
          state_next = ST_YELLOW;
        end
      end
      ST_YELLOW: if (timer >= Y_LAST) state_next = ST_ALL_RED;
      ST_WALK:   if (emg_valid || timer >= W_LAST) state_next = ST_ALL_RED;
      default:   state_next = ST_IDLE;
    endcase

    timer_next = (state_next != state) ? 8'd0 :
                 (timer == 8'hFF)      ? timer : timer + 8'd1;
    enter_walk = (state_next == ST_WALK) && (state != ST_WALK);
    ped_next   = ped_req || (ped_pending && !enter_walk);
    green_d    = (state_next == ST_GREEN)  ? dir_onehot(dir_next) : 4'b0000;
    yellow_d   = (state_next == ST_YELLOW) ? dir_onehot(dir_next) : 4'b0000;
    done_d     = (state_next == ST_YELLOW) && (timer_next == Y_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      timer       <= 8'd0;
      ped_pending <= 1'b0;
      rr_ptr      <= 2'd3;
      cur_dir     <= 2'd0;
      green       <= 4'b0000;
      yellow      <= 4'b0000;
      red         <= 4'b1111;
      walk        <= 1'b0;
      phase_done  <= 1'b0;
    end else begin
      state       <= state_next;
      timer       <= timer_next;
      ped_pending <= ped_next;
      rr_ptr      <= ptr_next;
      cur_dir     <= dir_next;
      green       <= green_d;
      yellow      <= yellow_d;
      red         <= ~(green_d | yellow_d);
      walk        <= (state_next == ST_WALK);
      phase_done  <= done_d;
    end
  end

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// tb/tb_intersection_phase_scheduler.sv - directed vector bench for intersection_phase_scheduler
module tb_intersection_phase_scheduler;

  logic       clk = 1'b0;
  logic       rst, start, ped_req, emg_valid, walk, phase_done;
  logic [3:0] req, green, yellow, red;
  logic [1:0] emg_dir, cur_dir;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  intersection_phase_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .req        (req),
    .ped_req    (ped_req),
    .emg_valid  (emg_valid),
    .emg_dir    (emg_dir),
    .green      (green),
    .yellow     (yellow),
    .red        (red),
    .walk       (walk),
    .cur_dir    (cur_dir),
    .phase_done (phase_done)
  );

  typedef struct {
    logic       rst, start;
    logic [3:0] req;
    logic       ped, emg;
    logic [1:0] edir;
    logic [3:0] g, y;
    logic       w;
    logic [1:0] dir;
    logic       pd;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, s, input logic [3:0] rq, input logic p, e, input logic [1:0] ed,
                     input logic [3:0] eg, ey, input logic ew, input logic [1:0] edr, input logic epd);
    vec_t v;
    v.rst = r; v.start = s; v.req = rq; v.ped = p; v.emg = e; v.edir = ed;
    v.g = eg; v.y = ey; v.w = ew; v.dir = edr; v.pd = epd;
    vq.push_back(v);
  endtask

  task automatic drive(input logic r, s, input logic [3:0] rq, input logic p, e, input logic [1:0] ed);
    rst = r; start = s; req = rq; ped_req = p; emg_valid = e; emg_dir = ed;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [3:0] eg, ey, input logic ew,
                       input logic [1:0] edr, input logic epd);
    logic [3:0]  er;
    logic [15:0] exp_v, act_v;
    er    = ~(eg | ey);
    exp_v = {eg, ey, er, ew, edr, epd};
    act_v = {green, yellow, red, walk, cur_dir, phase_done};
    total++;
    if (act_v !== exp_v) begin
      bad++;
      $display("FAIL %s: got g=%b y=%b r=%b walk=%b dir=%0d pd=%b, expected g=%b y=%b r=%b walk=%b dir=%0d pd=%b",
               nm, green, yellow, red, walk, cur_dir, phase_done, eg, ey, er, ew, edr, epd);
    end
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst, vq[i].start, vq[i].req, vq[i].ped, vq[i].emg, vq[i].edir);
      check($sformatf("%s[%0d]", tag, i), vq[i].g, vq[i].y, vq[i].w, vq[i].dir, vq[i].pd);
    end
    vq.delete();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; req = 4'b0000; ped_req = 1'b0; emg_valid = 1'b0; emg_dir = 2'd0;

    // single requester: served after one all-red cycle, then rests in green
    add(1, 0, 4'b0001, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    add(1, 0, 4'b0001, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    add(0, 1, 4'b0001, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    for (int i = 0; i < 6; i++) add(0, 1, 4'b0001, 0, 0, 0, 4'b0001, 4'b0000, 0, 0, 0);
    run_table("rest");
    repeat (300) drive(0, 1, 4'b0001, 0, 0, 0);
    check("rest_saturated", 4'b0001, 4'b0000, 0, 0, 0);

    // two requesters alternate 0,2,0 with 4 green / 2 yellow / 1 all-red
    add(1, 0, 4'b0101, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    add(0, 1, 4'b0101, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 1, 4'b0101, 0, 0, 0, 4'b0001, 4'b0000, 0, 0, 0);
    add(0, 1, 4'b0101, 0, 0, 0, 4'b0000, 4'b0001, 0, 0, 0);
    add(0, 1, 4'b0101, 0, 0, 0, 4'b0000, 4'b0001, 0, 0, 1);
    add(0, 1, 4'b0101, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 1, 4'b0101, 0, 0, 0, 4'b0100, 4'b0000, 0, 2, 0);
    add(0, 1, 4'b0101, 0, 0, 0, 4'b0000, 4'b0100, 0, 2, 0);
    add(0, 1, 4'b0101, 0, 0, 0, 4'b0000, 4'b0100, 0, 2, 1);
    add(0, 1, 4'b0101, 0, 0, 0, 4'b0000, 4'b0000, 0, 2, 0);
    add(0, 1, 4'b0101, 0, 0, 0, 4'b0001, 4'b0000, 0, 0, 0);
    add(0, 1, 4'b0101, 0, 0, 0, 4'b0001, 4'b0000, 0, 0, 0);
    run_table("alt");

    // pedestrian during green: walk for 3 cycles, then pending is gone
    add(1, 0, 4'b0001, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    add(0, 1, 4'b0001, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    add(0, 1, 4'b0001, 0, 0, 0, 4'b0001, 4'b0000, 0, 0, 0);
    add(0, 1, 4'b0001, 1, 0, 0, 4'b0001, 4'b0000, 0, 0, 0);
    add(0, 1, 4'b0001, 0, 0, 0, 4'b0001, 4'b0000, 0, 0, 0);
    add(0, 1, 4'b0001, 0, 0, 0, 4'b0001, 4'b0000, 0, 0, 0);
    add(0, 1, 4'b0001, 0, 0, 0, 4'b0000, 4'b0001, 0, 0, 0);
    add(0, 1, 4'b0001, 0, 0, 0, 4'b0000, 4'b0001, 0, 0, 1);
    add(0, 1, 4'b0001, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 1, 4'b0001, 0, 0, 0, 4'b0000, 4'b0000, 1, 0, 0);
    add(0, 1, 4'b0001, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(0, 1, 4'b0001, 0, 0, 0, 4'b0001, 4'b0000, 0, 0, 0);
    run_table("ped");

    // demand arriving after G_MIN waits until G_MAX
    add(1, 0, 4'b0001, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    add(0, 1, 4'b0001, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    for (int i = 0; i < 6; i++) add(0, 1, 4'b0001, 0, 0, 0, 4'b0001, 4'b0000, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 1, 4'b0011, 0, 0, 0, 4'b0001, 4'b0000, 0, 0, 0);
    add(0, 1, 4'b0011, 0, 0, 0, 4'b0000, 4'b0001, 0, 0, 0);
    add(0, 1, 4'b0011, 0, 0, 0, 4'b0000, 4'b0001, 0, 0, 1);
    add(0, 1, 4'b0011, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0);
    add(0, 1, 4'b0011, 0, 0, 0, 4'b0010, 4'b0000, 0, 1, 0);
    run_table("gmax");

    // emergency on approach 3 preempts green on approach 1
    drive(1, 0, 4'b0010, 0, 0, 0); check("emg_reset", 4'b0000, 4'b0000, 0, 0, 0);
    drive(0, 1, 4'b0010, 0, 0, 0); check("emg_allred", 4'b0000, 4'b0000, 0, 0, 0);
    drive(0, 1, 4'b0010, 0, 0, 0); check("emg_g1_t0", 4'b0010, 4'b0000, 0, 1, 0);
    drive(0, 1, 4'b0010, 0, 0, 0); check("emg_g1_t1", 4'b0010, 4'b0000, 0, 1, 0);
    drive(0, 1, 4'b0010, 0, 1, 3); check("emg_y1_a", 4'b0000, 4'b0010, 0, 1, 0);
    drive(0, 1, 4'b0010, 0, 1, 3); check("emg_y1_b", 4'b0000, 4'b0010, 0, 1, 1);
    drive(0, 1, 4'b0010, 0, 1, 3); check("emg_ar", 4'b0000, 4'b0000, 0, 1, 0);
    drive(0, 1, 4'b0010, 0, 1, 3); check("emg_g3", 4'b1000, 4'b0000, 0, 3, 0);
    for (int i = 0; i < 12; i++) begin
      drive(0, 1, 4'b0010, 0, 1, 3);
      check($sformatf("emg_hold[%0d]", i), 4'b1000, 4'b0000, 0, 3, 0);
    end
    drive(0, 1, 4'b0010, 0, 0, 0); check("emg_release", 4'b0000, 4'b1000, 0, 3, 0);

    // reset in the middle of yellow, then approach 0 is served first
    drive(1, 0, 4'b0101, 0, 0, 0); check("ry_reset", 4'b0000, 4'b0000, 0, 0, 0);
    drive(0, 1, 4'b0101, 0, 0, 0);
    repeat (4) drive(0, 1, 4'b0101, 0, 0, 0);
    drive(0, 1, 4'b0101, 0, 0, 0); check("ry_yellow", 4'b0000, 4'b0001, 0, 0, 0);
    drive(1, 0, 4'b0101, 0, 0, 0); check("ry_midreset", 4'b0000, 4'b0000, 0, 0, 0);
    drive(0, 1, 4'b1111, 0, 0, 0); check("ry_allred", 4'b0000, 4'b0000, 0, 0, 0);
    drive(0, 1, 4'b1111, 0, 0, 0); check("ry_first0", 4'b0001, 4'b0000, 0, 0, 0);

    // emergency beats pending pedestrian; walk abort and same-cycle re-press
    drive(1, 0, 4'b0000, 0, 0, 0); check("ep_reset", 4'b0000, 4'b0000, 0, 0, 0);
    drive(0, 1, 4'b0000, 0, 0, 0); check("ep_ar1", 4'b0000, 4'b0000, 0, 0, 0);
    drive(0, 1, 4'b0000, 1, 0, 0); check("ep_ar2", 4'b0000, 4'b0000, 0, 0, 0);
    drive(0, 1, 4'b0000, 0, 1, 2); check("ep_g2", 4'b0100, 4'b0000, 0, 2, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 4'b0000, 0, 1, 2);
      check($sformatf("ep_hold[%0d]", i), 4'b0100, 4'b0000, 0, 2, 0);
    end
    drive(0, 1, 4'b0000, 0, 0, 0); check("ep_y_a", 4'b0000, 4'b0100, 0, 2, 0);
    drive(0, 1, 4'b0000, 0, 0, 0); check("ep_y_b", 4'b0000, 4'b0100, 0, 2, 1);
    drive(0, 1, 4'b0000, 0, 0, 0); check("ep_ar3", 4'b0000, 4'b0000, 0, 2, 0);
    drive(0, 1, 4'b0000, 1, 0, 0); check("ep_walk", 4'b0000, 4'b0000, 1, 2, 0);
    drive(0, 1, 4'b0000, 0, 1, 1); check("ep_abort", 4'b0000, 4'b0000, 0, 2, 0);
    drive(0, 1, 4'b0000, 0, 1, 1); check("ep_g1", 4'b0010, 4'b0000, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 4'b0000, 0, 0, 0);
      check($sformatf("ep_g1min[%0d]", i), 4'b0010, 4'b0000, 0, 1, 0);
    end
    drive(0, 1, 4'b0000, 0, 0, 0); check("ep_y1_a", 4'b0000, 4'b0010, 0, 1, 0);
    drive(0, 1, 4'b0000, 0, 0, 0); check("ep_y1_b", 4'b0000, 4'b0010, 0, 1, 1);
    drive(0, 1, 4'b0000, 0, 0, 0); check("ep_ar4", 4'b0000, 4'b0000, 0, 1, 0);
    drive(0, 1, 4'b0000, 0, 0, 0); check("ep_walk2", 4'b0000, 4'b0000, 1, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
